morse_sequence_player: RTL and testbench

MORSE_SEQUENCE_PLAYER -- requirements
Module: morse_sequence_player

---
 rtl/morse_pkg.sv | 65 ++++++
 rtl/morse_sequence_player_if.sv | 28 ++
 rtl/morse_unit_timer.sv | 57 +++++
 rtl/morse_sequence_player.sv | 184 ++++++++++++++++++
 tb/tb_morse_sequence_player.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse sequence player:
//   - sym_e    : 2-bit symbol codes carried in each EncSeq slot
//   - state_e  : player FSM states
//   - sig_e    : 3-bit codes of the regenerated producer-side symbol stream
//   - UNITS_*  : phase lengths in Morse time units
//   - helpers  : slot extraction and per-symbol phase length
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        SYM_DOT     = 2'b00,
        SYM_DASH    = 2'b01,
        SYM_ILLEGAL = 2'b10,
        SYM_TERM    = 2'b11
    } sym_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_GAP   = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SIG_DOT        = 3'b000,
        SIG_DASH       = 3'b001,
        SIG_LETTER_END = 3'b010,
        SIG_WORD_END   = 3'b011,
        SIG_NONE       = 3'b111
    } sig_e;

    localparam logic [2:0] UNITS_DOT        = 3'd1;
    localparam logic [2:0] UNITS_DASH       = 3'd3;
    localparam logic [2:0] UNITS_GAP        = 3'd1;
    localparam logic [2:0] UNITS_LETTER_GAP = 3'd3;
    localparam logic [2:0] UNITS_WORD_GAP   = 3'd7;

    localparam int unsigned NUM_SLOTS = 5;

    // Slot 0 sits in the most significant pair so a letter reads left to right.
    function automatic sym_e slot_sym(input logic [9:0] enc, input logic [2:0] k);
        case (k)
            3'd0:    return sym_e'(enc[9:8]);
            3'd1:    return sym_e'(enc[7:6]);
            3'd2:    return sym_e'(enc[5:4]);
            3'd3:    return sym_e'(enc[3:2]);
            default: return sym_e'(enc[1:0]);
        endcase
    endfunction

    function automatic logic is_mark(input sym_e s);
        return (s == SYM_DOT) || (s == SYM_DASH);
    endfunction

    function automatic logic [2:0] mark_units(input sym_e s);
        return (s == SYM_DASH) ? UNITS_DASH : UNITS_DOT;
    endfunction

    function automatic logic [2:0] trail_units(input logic letter_gap);
        return letter_gap ? UNITS_LETTER_GAP : UNITS_WORD_GAP;
    endfunction

endpackage

// File: rtl/morse_sequence_player_if.sv
// -----------------------------------------------------------------------------
// morse_sequence_player_if
// Bundles the sequence handshake and player status so a producer and the
// player can be wired with one connection.
//   master : sequence producer (drives enc_seq / space_end_seqbar / seq_valid)
//   slave  : player side (drives seq_ready / key / busy / seq_error)
// -----------------------------------------------------------------------------
interface morse_sequence_player_if;

    logic [9:0] enc_seq;
    logic       space_end_seqbar;
    logic       seq_valid;
    logic       seq_ready;
    logic       key;
    logic       busy;
    logic       seq_error;

    modport master (
        output enc_seq, space_end_seqbar, seq_valid,
        input  seq_ready, key, busy, seq_error
    );

    modport slave (
        input  enc_seq, space_end_seqbar, seq_valid,
        output seq_ready, key, busy, seq_error
    );

endinterface

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Phase timer. A load of N units (sampled on the rising edge with load=1)
// makes done pulse high for exactly one cycle, N*UNIT_CYCLES cycles after
// that edge, so the owner can change phase on the edge that ends the pulse.
// A load in the cycle where done is high restarts the timer seamlessly.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new phase
//   units      : phase length in Morse units (1..7)
//   done       : last cycle of the phase
// -----------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] units,
    output logic       done
);

    // Longest phase is 7 units; the counter holds (7*UNIT_CYCLES - 1) at most,
    // so it never wraps inside a phase.
    localparam int CW = $clog2(UNIT_CYCLES * 7);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = CW'(int'(units) * UNIT_CYCLES - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) active_d = 1'b0;
            else             cnt_d    = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/morse_sequence_player.sv
// -----------------------------------------------------------------------------
// morse_sequence_player
// Plays one encoded Morse letter (up to five dot/dash slots) as a keyed tone:
// marks for each symbol, one-unit gaps between them, then a letter (3-unit)
// or word (7-unit) trailing silence. One sequence at a time, no queuing.
//   Clk, Resetbar    : clock, asynchronous active-low reset
//   EncSeq           : five 2-bit slots, slot 0 in [9:8]
//   Space_EndSeqbar  : 1 = letter gap follows, 0 = word gap follows
//   SeqValid/SeqReady: accept handshake (ready only while idle)
//   Key              : 1 = tone on
//   Busy             : sequence in progress (= !SeqReady)
//   SeqError         : one-cycle pulse when an illegal slot code is reached
// Optional (MORSE_PLAYER_SIGNAL_ECHO_EN defined):
//   Signals, SignalValid : regenerated symbol stream, one pulse per mark
//                          entry and one at trail entry
// -----------------------------------------------------------------------------
module morse_sequence_player
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       Clk,
    input  logic       Resetbar,
    input  logic [9:0] EncSeq,
    input  logic       Space_EndSeqbar,
    input  logic       SeqValid,
    output logic       SeqReady,
    output logic       Key,
    output logic       Busy,
`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
    output logic [2:0] Signals,
    output logic       SignalValid,
`endif
    output logic       SeqError
);

    state_e     state_q, state_d;
    logic [9:0] enc_q, enc_d;
    logic       space_q, space_d;
    logic [2:0] slot_q, slot_d;
    logic       key_q, key_d;
    logic       err_q, err_d;

    logic       tmr_load;
    logic [2:0] tmr_units;
    logic       tmr_done;

    sym_e       sym;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk   (Clk),
        .rst_n (Resetbar),
        .load  (tmr_load),
        .units (tmr_units),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        enc_d     = enc_q;
        space_d   = space_q;
        slot_d    = slot_q;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_units = UNITS_GAP;
        sym       = SYM_TERM;

        case (state_q)
            ST_IDLE: begin
                if (SeqValid) begin
                    enc_d    = EncSeq;
                    space_d  = Space_EndSeqbar;
                    slot_d   = 3'd0;
                    sym      = slot_sym(EncSeq, 3'd0);
                    tmr_load = 1'b1;
                    if (is_mark(sym)) begin
                        state_d   = ST_MARK;
                        tmr_units = mark_units(sym);
                    end else begin
                        state_d   = ST_TRAIL;
                        tmr_units = trail_units(Space_EndSeqbar);
                        err_d     = (sym == SYM_ILLEGAL);
                    end
                end
            end

            ST_MARK: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    // Last slot has no successor: go straight to the trail.
                    if (slot_q != 3'(NUM_SLOTS - 1)) begin
                        sym = slot_sym(enc_q, slot_q + 3'd1);
                    end
                    if (is_mark(sym)) begin
                        state_d   = ST_GAP;
                        tmr_units = UNITS_GAP;
                        slot_d    = slot_q + 3'd1;
                    end else begin
                        state_d   = ST_TRAIL;
                        tmr_units = trail_units(space_q);
                        err_d     = (sym == SYM_ILLEGAL);
                    end
                end
            end

            ST_GAP: begin
                if (tmr_done) begin
                    sym       = slot_sym(enc_q, slot_q);
                    state_d   = ST_MARK;
                    tmr_load  = 1'b1;
                    tmr_units = mark_units(sym);
                end
            end

            ST_TRAIL: begin
                if (tmr_done) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        key_d = (state_d == ST_MARK);
    end

    always_ff @(posedge Clk or negedge Resetbar) begin
        if (!Resetbar) begin
            state_q <= ST_IDLE;
            enc_q   <= '0;
            space_q <= 1'b0;
            slot_q  <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            space_q <= space_d;
            slot_q  <= slot_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign SeqReady = (state_q == ST_IDLE);
    assign Busy     = ~SeqReady;
    assign Key      = key_q;
    assign SeqError = err_q;

`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
    logic [2:0] signals_q, signals_d;
    logic       sig_valid_q, sig_valid_d;
    logic       enter_mark, enter_trail;

    // Marks are only entered from IDLE or GAP and the trail only from IDLE or
    // MARK, so a state change into either is exactly one entry event. The
    // loaded unit count tells dash from dot and word gap from letter gap.
    always_comb begin
        enter_mark  = (state_d == ST_MARK)  && (state_q != ST_MARK);
        enter_trail = (state_d == ST_TRAIL) && (state_q != ST_TRAIL);
        signals_d   = signals_q;
        sig_valid_d = enter_mark || enter_trail;
        if (enter_mark) begin
            signals_d = (tmr_units == UNITS_DASH) ? SIG_DASH : SIG_DOT;
        end else if (enter_trail) begin
            signals_d = (tmr_units == UNITS_WORD_GAP) ? SIG_WORD_END : SIG_LETTER_END;
        end
    end

    always_ff @(posedge Clk or negedge Resetbar) begin
        if (!Resetbar) begin
            signals_q   <= SIG_NONE;
            sig_valid_q <= 1'b0;
        end else begin
            signals_q   <= signals_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    assign Signals     = signals_q;
    assign SignalValid = sig_valid_q;
`endif

endmodule

// File: tb/tb_morse_sequence_player.sv
// -----------------------------------------------------------------------------
// tb_morse_sequence_player
// Directed bench for morse_sequence_player with UNIT_CYCLES=4. Each directed
// step pushes the expected per-cycle Key/Busy/SeqError pattern into a queue,
// sends one sequence, then pops one entry per cycle and compares it with the
// outputs sampled on the falling edge. With MORSE_PLAYER_SIGNAL_ECHO_EN the
// regenerated symbol stream is also checked against its own queue.
// -----------------------------------------------------------------------------
module tb_morse_sequence_player;

    localparam int U = 4;

    typedef struct packed {
        logic key;
        logic busy;
        logic err;
    } exp_t;

    logic Clk;
    logic Resetbar;

    morse_sequence_player_if seq_if ();

`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
    logic [2:0] signals;
    logic       signal_valid;
    logic [2:0] sig_q[$];
    logic       echo_on;
`endif

    exp_t exp_q[$];
    int   total;
    int   bad;

    morse_sequence_player #(
        .UNIT_CYCLES (U)
    ) dut (
        .Clk             (Clk),
        .Resetbar        (Resetbar),
        .EncSeq          (seq_if.enc_seq),
        .Space_EndSeqbar (seq_if.space_end_seqbar),
        .SeqValid        (seq_if.seq_valid),
        .SeqReady        (seq_if.seq_ready),
        .Key             (seq_if.key),
        .Busy            (seq_if.busy),
`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
        .Signals         (signals),
        .SignalValid     (signal_valid),
`endif
        .SeqError        (seq_if.seq_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n busy cycles with the given key level; err marks the first of them.
    task automatic push(input logic key, input logic err, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{key: key, busy: 1'b1, err: (err && i == 0)});
        end
    endtask

    task automatic push_idle();
        exp_q.push_back('{key: 1'b0, busy: 1'b0, err: 1'b0});
    endtask

    task automatic send(input logic [9:0] enc, input logic space);
        @(negedge Clk);
        seq_if.enc_seq          = enc;
        seq_if.space_end_seqbar = space;
        seq_if.seq_valid        = 1'b1;
        @(posedge Clk);
    endtask

    // Pops up to n expectations, one per cycle. With noisy=1 the inputs are
    // scrambled and SeqValid held high while the player is expected busy.
    task automatic drain(input string tag, input int n, input logic noisy);
        exp_t e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] key/busy/ready/err", tag, i),
                  {28'd0, seq_if.key, seq_if.busy, seq_if.seq_ready, seq_if.seq_error},
                  {28'd0, e.key, e.busy, ~e.busy, e.err});
            if (noisy && e.busy) begin
                seq_if.seq_valid        = 1'b1;
                seq_if.enc_seq          = 10'($urandom);
                seq_if.space_end_seqbar = 1'($urandom);
            end else begin
                seq_if.seq_valid = 1'b0;
            end
        end
    endtask

    task automatic push_letter_a(input logic space);
        push(1'b1, 1'b0, U);
        push(1'b0, 1'b0, U);
        push(1'b1, 1'b0, 3 * U);
        push(1'b0, 1'b0, (space ? 3 : 7) * U);
        push_idle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_key"},   {31'd0, seq_if.key},       32'd0);
        check({tag, "_ready"}, {31'd0, seq_if.seq_ready}, 32'd1);
        check({tag, "_busy"},  {31'd0, seq_if.busy},      32'd0);
        check({tag, "_err"},   {31'd0, seq_if.seq_error}, 32'd0);
`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
        check({tag, "_signals"}, {29'd0, signals},      32'h7);
        check({tag, "_sigval"},  {31'd0, signal_valid}, 32'd0);
`endif
    endtask

`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
    always @(negedge Clk) begin
        if (echo_on && signal_valid) begin
            if (sig_q.size() == 0) begin
                check("echo_unexpected", {29'd0, signals}, 32'hffff_ffff);
            end else begin
                check("echo_code", {29'd0, signals}, {29'd0, sig_q.pop_front()});
            end
        end
    end
`endif

    initial begin
        total = 0;
        bad   = 0;
        Resetbar                = 1'b0;
        seq_if.seq_valid        = 1'b0;
        seq_if.enc_seq          = '0;
        seq_if.space_end_seqbar = 1'b1;
`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
        echo_on = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        check_reset_state("reset");
        Resetbar = 1'b1;

        // "A", letter gap: 4 on, 4 off, 12 on, 12 off; ready 32 cycles later.
        push_letter_a(1'b1);
        send(10'b0001111111, 1'b1);
        drain("A", 64, 1'b1);

        // "0", word gap: five 12-cycle dashes, 4-cycle gaps, 28-cycle trail.
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b0, 3 * U);
            if (i < 4) push(1'b0, 1'b0, U);
        end
        push(1'b0, 1'b0, 7 * U);
        push_idle();
        send(10'b0101010101, 1'b0);
        drain("zero", 200, 1'b0);

        // Empty sequence: trail only, key held low.
        push(1'b0, 1'b0, 3 * U);
        push_idle();
        send(10'b1111111111, 1'b1);
        drain("empty", 64, 1'b0);

        // Dot then illegal: 4-cycle dot, error pulse, 12-cycle trail.
        push(1'b1, 1'b0, U);
        push(1'b0, 1'b1, 3 * U);
        push_idle();
        send(10'b0010111111, 1'b1);
        drain("illegal", 64, 1'b0);

        // Illegal in slot 0: error pulse straight into a word trail.
        push(1'b0, 1'b1, 7 * U);
        push_idle();
        send(10'b1000000000, 1'b0);
        drain("illegal0", 64, 1'b0);

        // Reset mid-dash, then a clean "A".
        push_letter_a(1'b1);
        send(10'b0001111111, 1'b1);
        drain("pre_rst", 12, 1'b0);
        Resetbar = 1'b0;
        #1;
        check_reset_state("mid_rst");
        exp_q.delete();
        @(negedge Clk);
        Resetbar = 1'b1;
        push_letter_a(1'b1);
        send(10'b0001111111, 1'b1);
        drain("post_rst", 64, 1'b0);

`ifdef MORSE_PLAYER_SIGNAL_ECHO_EN
        // "A", word gap: echo stream 000, 001, 011.
        sig_q.push_back(3'b000);
        sig_q.push_back(3'b001);
        sig_q.push_back(3'b011);
        echo_on = 1'b1;
        push_letter_a(1'b0);
        send(10'b0001111111, 1'b0);
        drain("echo_A", 64, 1'b0);
        echo_on = 1'b0;
        check("echo_drained", sig_q.size(), 32'd0);
        check("echo_hold", {29'd0, signals}, 32'h3);
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
